// File: rtl/scoreboard_hazard_unit_if.sv
// Decode/writeback/completion bundle for the scoreboard hazard unit.
// The master modport is the pipeline side and the slave modport is the hazard unit.
interface scoreboard_hazard_unit_if #(
  parameter int MAX_OUT = 4,
  parameter int RW      = 5
);
  localparam int OW = $clog2(MAX_OUT + 1);

  logic          issue_valid;
  logic [RW-1:0] issue_rs1, issue_rs2;
  logic          issue_use_rs1, issue_use_rs2;
  logic [RW-1:0] issue_rd;
  logic          issue_reg_wr;
  logic          issue_long;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic          wb_reg_wr;
  logic          complete_valid;
  logic [RW-1:0] complete_rd;
  logic          br_taken;
  logic          epc_taken;
  logic          drain_req;
  logic          stall;
  logic          flush;
  logic [1:0]    forw_a, forw_b;
  logic [OW-1:0] outstanding;
  logic          drain_busy;
  logic          seq_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_reg_wr, issue_long, wb_valid, wb_rd, wb_reg_wr,
           complete_valid, complete_rd, br_taken, epc_taken, drain_req,
    input  stall, flush, forw_a, forw_b, outstanding, drain_busy, seq_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_reg_wr, issue_long, wb_valid, wb_rd, wb_reg_wr,
           complete_valid, complete_rd, br_taken, epc_taken, drain_req,
    output stall, flush, forw_a, forw_b, outstanding, drain_busy, seq_err
  );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit: a per-register busy scoreboard plus an in-order
// destination FIFO for variable-latency long ops. It produces decode stall,
// operand forwarding selects, flush, and a drain indication.

// Per-source check: RAW hit against the scoreboard and forwarding select.
// Index 0 never hits and is never forwarded.
module sb_src_check #(
  parameter int RW = 5
) (
  input  logic [RW-1:0] rs,
  input  logic          use_rs,
  input  logic          busy_rs,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_rd,
  input  logic          cv,
  input  logic [RW-1:0] crd,
  output logic          raw,
  output logic [1:0]    forw
);
  logic nz, cv_hit;
  assign nz     = (rs != '0);
  assign cv_hit = cv & (crd == rs);
  assign raw    = use_rs & nz & busy_rs & ~cv_hit;

  // Writeback ALU result beats completion data; regfile otherwise.
  always_comb begin
    forw = 2'b00;
    if (nz && wb_en && wb_rd == rs) forw = 2'b01;
    else if (nz && cv_hit)          forw = 2'b10;
  end
endmodule

module scoreboard_hazard_unit #(
  parameter int NREG    = 32,
  parameter int MAX_OUT = 4,
  parameter int RW      = 5
) (
  input logic clk,
  input logic rst,
  scoreboard_hazard_unit_if.slave io
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int PW = $clog2(MAX_OUT);

  logic [NREG-1:0]      busy;
  logic [RW-1:0]        fifo_q [MAX_OUT];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [OW-1:0]        cnt;
  logic                 err_q;

  logic [1:0][RW-1:0]   srcs;
  logic [1:0]           uses, raws;
  logic [1:0][1:0]      forws;
  logic                 kill, fire, push, pop, waw, full, drain_busy, stall;
  logic                 cv_err;
  logic [NREG-1:0]      set_vec, clr_vec;

  assign srcs = {io.issue_rs2, io.issue_rs1};
  assign uses = {io.issue_use_rs2, io.issue_use_rs1};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_src
      sb_src_check #(.RW(RW)) u_chk (
        .rs      (srcs[g]),
        .use_rs  (uses[g]),
        .busy_rs (busy[srcs[g]]),
        .wb_en   (io.wb_valid & io.wb_reg_wr),
        .wb_rd   (io.wb_rd),
        .cv      (io.complete_valid),
        .crd     (io.complete_rd),
        .raw     (raws[g]),
        .forw    (forws[g])
      );
    end
  endgenerate

  assign kill       = io.br_taken | io.epc_taken;
  assign waw        = io.issue_reg_wr & (io.issue_rd != '0) & busy[io.issue_rd]
                    & ~(io.complete_valid & (io.complete_rd == io.issue_rd));
  // A same-cycle completion frees a slot, so a full FIFO does not block.
  assign full       = io.issue_long & (cnt == OW'(MAX_OUT)) & ~io.complete_valid;
  assign drain_busy = io.drain_req & (cnt != '0);
  assign stall      = io.issue_valid & (|raws | waw | full | drain_busy);
  assign fire       = io.issue_valid & ~stall & ~kill;
  assign push       = fire & io.issue_long;
  // A completion with nothing outstanding is an error and is not popped.
  assign pop        = io.complete_valid & (cnt != '0);
  assign cv_err     = io.complete_valid
                    & ((cnt == '0) | (io.complete_rd != fifo_q[rd_ptr]));

  // Clear first, then set, so that an issue to the completing register keeps it busy.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (push && io.issue_reg_wr && io.issue_rd != '0) set_vec[io.issue_rd] = 1'b1;
    if (io.complete_valid) clr_vec[io.complete_rd] = 1'b1;
  end

  // Scoreboard, pointers, occupancy, and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (cv_err) err_q <= 1'b1;
    end
  end

  // Destination FIFO storage. Stores and x0 targets push the sentinel 0.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= (io.issue_reg_wr) ? io.issue_rd : '0;
  end

  assign io.stall       = stall;
  assign io.flush       = kill | rst;
  assign io.forw_a      = forws[0];
  assign io.forw_b      = forws[1];
  assign io.outstanding = cnt;
  assign io.drain_busy  = drain_busy;
  assign io.seq_err     = err_q;
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit. A queue-based reference model
// predicts the outputs on every cycle, and literal checks pin the key scenarios.
module tb_scoreboard_hazard_unit;
  localparam int NREG = 32, MAX_OUT = 4, RW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scoreboard_hazard_unit_if #(.MAX_OUT(MAX_OUT), .RW(RW)) sif ();
  scoreboard_hazard_unit #(.NREG(NREG), .MAX_OUT(MAX_OUT), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (sif.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: registers awaiting long results, and the in-order completion queue.
  bit busy_m [NREG];
  int q_m [$];
  bit err_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit mb(int r);
    return (r != 0) && busy_m[r];
  endfunction

  function automatic bit cvm(int r);
    return sif.complete_valid && (int'(sif.complete_rd) == r);
  endfunction

  function automatic bit m_stall();
    bit raw1, raw2, waw, full, drn;
    raw1 = sif.issue_use_rs1 && mb(sif.issue_rs1) && !cvm(sif.issue_rs1);
    raw2 = sif.issue_use_rs2 && mb(sif.issue_rs2) && !cvm(sif.issue_rs2);
    waw  = sif.issue_reg_wr && mb(sif.issue_rd) && !cvm(sif.issue_rd);
    full = sif.issue_long && (q_m.size() == MAX_OUT) && !sif.complete_valid;
    drn  = sif.drain_req && (q_m.size() != 0);
    return sif.issue_valid && (raw1 || raw2 || waw || full || drn);
  endfunction

  function automatic int m_forw(int r);
    if (r == 0) return 0;
    if (sif.wb_valid && sif.wb_reg_wr && int'(sif.wb_rd) == r) return 1;
    if (cvm(r)) return 2;
    return 0;
  endfunction

  // Compare every output against the model at the falling edge.
  task automatic settle();
    @(negedge clk);
    chk("stall",       sif.stall,       m_stall());
    chk("flush",       sif.flush,       sif.br_taken | sif.epc_taken | rst);
    chk("forw_a",      sif.forw_a,      m_forw(sif.issue_rs1));
    chk("forw_b",      sif.forw_b,      m_forw(sif.issue_rs2));
    chk("outstanding", sif.outstanding, q_m.size());
    chk("drain_busy",  sif.drain_busy,  sif.drain_req && q_m.size() != 0);
    chk("seq_err",     sif.seq_err,     err_m);
  endtask

  // Advance the model with the current inputs, then cross the rising edge.
  task automatic tick();
    bit fire;
    int crd, rd;
    fire = sif.issue_valid && !m_stall() && !(sif.br_taken || sif.epc_taken);
    crd  = sif.complete_rd;
    rd   = sif.issue_rd;
    if (sif.complete_valid) begin
      if (q_m.size() == 0) err_m = 1'b1;
      else begin
        if (q_m[0] != crd) err_m = 1'b1;
        void'(q_m.pop_front());
      end
      if (crd != 0) busy_m[crd] = 1'b0;
    end
    if (fire && sif.issue_long) begin
      if (sif.issue_reg_wr && rd != 0) begin
        q_m.push_back(rd);
        busy_m[rd] = 1'b1;
      end else q_m.push_back(0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle();
    sif.issue_valid = 0; sif.issue_rs1 = 0; sif.issue_rs2 = 0;
    sif.issue_use_rs1 = 0; sif.issue_use_rs2 = 0; sif.issue_rd = 0;
    sif.issue_reg_wr = 0; sif.issue_long = 0; sif.wb_valid = 0;
    sif.wb_rd = 0; sif.wb_reg_wr = 0; sif.complete_valid = 0;
    sif.complete_rd = 0; sif.br_taken = 0; sif.epc_taken = 0;
    sif.drain_req = 0;
  endtask

  task automatic long_op(input int rd, input bit wr);
    idle();
    sif.issue_valid = 1; sif.issue_long = 1; sif.issue_reg_wr = wr;
    sif.issue_rd = RW'(rd);
  endtask

  task automatic complete(input int rd);
    idle();
    sif.complete_valid = 1; sif.complete_rd = RW'(rd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    q_m.delete();
    err_m = 1'b0;
    settle();
    chk("rst_flush", sif.flush, 1);
    chk("rst_outstanding", sif.outstanding, 0);
    chk("rst_seq_err", sif.seq_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();

    // Plain read with no long ops in flight.
    idle(); sif.issue_valid = 1; sif.issue_rs1 = 5; sif.issue_use_rs1 = 1;
    settle();
    chk("a_stall", sif.stall, 0);
    chk("a_forw_a", sif.forw_a, 0);
    tick();

    // Load to x7, a dependent add stalls, then a same-cycle completion forwards.
    long_op(7, 1); step();
    idle(); sif.issue_valid = 1; sif.issue_rs1 = 7; sif.issue_use_rs1 = 1;
    sif.issue_rd = 10; sif.issue_reg_wr = 1;
    settle(); chk("b_raw_stall", sif.stall, 1); tick();
    sif.complete_valid = 1; sif.complete_rd = 7;
    settle();
    chk("b_cv_stall", sif.stall, 0);
    chk("b_forw_a", sif.forw_a, 2);
    tick();
    idle(); sif.issue_valid = 1; sif.issue_rs1 = 7; sif.issue_use_rs1 = 1;
    settle(); chk("b_busy7_clear", sif.stall, 0); tick();

    // Fill the FIFO, stall the 5th op, then push and pop together at full.
    for (int r = 1; r <= 4; r++) begin long_op(r, 1); step(); end
    long_op(5, 1);
    settle();
    chk("c_full_out", sif.outstanding, 4);
    chk("c_full_stall", sif.stall, 1);
    tick();
    sif.complete_valid = 1; sif.complete_rd = 1;
    settle(); chk("c_pushpop_stall", sif.stall, 0); tick();
    idle(); settle(); chk("c_out_after", sif.outstanding, 4); tick();
    for (int r = 2; r <= 5; r++) begin complete(r); step(); end
    idle(); settle();
    chk("c_wrap_err", sif.seq_err, 0);
    chk("c_drained", sif.outstanding, 0);
    tick();

    // Branch kill of a long op to x9; the older op to x6 still completes.
    long_op(6, 1); step();
    long_op(9, 1); sif.br_taken = 1;
    settle(); chk("d_flush", sif.flush, 1); tick();
    idle(); sif.issue_valid = 1; sif.issue_rs1 = 9; sif.issue_use_rs1 = 1;
    settle();
    chk("d_busy9_clear", sif.stall, 0);
    chk("d_out_unchanged", sif.outstanding, 1);
    tick();
    long_op(11, 1); sif.epc_taken = 1; step();
    complete(6); step();
    idle(); settle();
    chk("d_old_done", sif.outstanding, 0);
    chk("d_no_err", sif.seq_err, 0);
    tick();

    // x0 guard: a long op to x0, with writeback to x0 and rs1 = 0.
    long_op(0, 1); sif.issue_rs1 = 0; sif.issue_use_rs1 = 1;
    sif.wb_valid = 1; sif.wb_reg_wr = 1; sif.wb_rd = 0;
    settle();
    chk("e_stall", sif.stall, 0);
    chk("e_forw_a", sif.forw_a, 0);
    tick();
    idle(); sif.issue_valid = 1; sif.issue_use_rs1 = 1; sif.issue_rd = 0;
    sif.issue_reg_wr = 1;
    settle(); chk("e_x0_never_busy", sif.stall, 0); tick();
    idle(); sif.wb_valid = 1; sif.wb_reg_wr = 1; sif.wb_rd = 12;
    sif.issue_rs2 = 12; sif.complete_valid = 1; sif.complete_rd = 12;
    settle(); chk("e_wb_priority", sif.forw_b, 1); tick();
    long_op(0, 0); step();
    complete(0); step();
    complete(0); step();

    // Out-of-order completion error, then drain with two ops outstanding.
    do_reset();
    for (int r = 2; r <= 4; r++) begin long_op(r, 1); step(); end
    complete(3); step();
    idle(); sif.issue_valid = 1; sif.drain_req = 1;
    settle();
    chk("f_seq_err", sif.seq_err, 1);
    chk("f_out2", sif.outstanding, 2);
    chk("f_drain_busy", sif.drain_busy, 1);
    chk("f_drain_stall", sif.stall, 1);
    tick();
    sif.complete_valid = 1; sif.complete_rd = 3; step();
    sif.complete_rd = 4; step();
    idle(); sif.issue_valid = 1; sif.drain_req = 1;
    settle();
    chk("f_drain_done", sif.drain_busy, 0);
    chk("f_drain_nostall", sif.stall, 0);
    chk("f_err_sticky", sif.seq_err, 1);
    tick();
    complete(8); step();

    // Reset clears the error, and a stray completion after reset sets it again.
    do_reset();
    complete(5); step();
    idle(); settle(); chk("g_err_after_rst", sif.seq_err, 1); tick();
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
